// File: rtl/apb_initiator.sv
// APB initiator: turns one command/response handshake into a single APB transfer,
// with a bounded wait-state budget that aborts a hung completer.
module apb_initiator #(
  parameter int TIMEOUT = 16,
  parameter int AW      = 12
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [31:0]   cmd_wdata,
  input  logic [3:0]    cmd_strb,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic          rsp_timeout,
  output logic          m_psel,
  output logic          m_penable,
  output logic          m_pwrite,
  output logic [AW-1:0] m_paddr,
  output logic [31:0]   m_pwdata,
  output logic [3:0]    m_pstrb,
  input  logic [31:0]   m_prdata,
  input  logic          m_pready,
  input  logic          m_pslverr
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam logic [CW-1:0] WAIT_MAX = '1;
  localparam logic [CW:0]   WAIT_LIM = (CW + 1)'(TIMEOUT);

  logic [1:0]    state_q, state_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          psel_q, psel_d;
  logic          penable_q, penable_d;
  logic          pwrite_q, pwrite_d;
  logic [AW-1:0] paddr_q, paddr_d;
  logic [31:0]   pwdata_q, pwdata_d;
  logic [3:0]    pstrb_q, pstrb_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          tmo_q, tmo_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          timeout_hit;

  // The cycle that would bring the wait count up to TIMEOUT is the last one allowed.
  assign timeout_hit = (TIMEOUT > 0) &&
                       (({1'b0, wait_q} + (CW + 1)'(1)) >= WAIT_LIM);

  // NOTE: every _d gets its _q value first, so no path through the case can infer a latch.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    tmo_d       = tmo_q;
    wait_d      = wait_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d     = S_SETUP;
          cmd_ready_d = 1'b0;
          psel_d      = 1'b1;
          penable_d   = 1'b0;
          pwrite_d    = cmd_write;
          paddr_d     = cmd_addr;
          pwdata_d    = cmd_write ? cmd_wdata : 32'h0;
          pstrb_d     = cmd_write ? cmd_strb  : 4'h0;
        end else begin
          cmd_ready_d = 1'b1;
        end
      end
      S_SETUP: begin
        state_d   = S_ACCESS;
        penable_d = 1'b1;
        wait_d    = '0;
      end
      S_ACCESS: begin
        // A completion in the same cycle as the timeout takes priority over the abort.
        if (m_pready) begin
          state_d     = S_RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rdata_d     = pwrite_q ? 32'h0 : m_prdata;
          err_d       = m_pslverr;
          tmo_d       = 1'b0;
        end else begin
          if (wait_q != WAIT_MAX) wait_d = wait_q + CW'(1);
          if (timeout_hit) begin
            state_d     = S_RESP;
            psel_d      = 1'b0;
            penable_d   = 1'b0;
            rsp_valid_d = 1'b1;
            rdata_d     = 32'h0;
            err_d       = 1'b1;
            tmo_d       = 1'b1;
          end
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= 32'h0;
      pstrb_q     <= 4'h0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 32'h0;
      err_q       <= 1'b0;
      tmo_q       <= 1'b0;
      wait_q      <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      tmo_q       <= tmo_d;
      wait_q      <= wait_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign rsp_timeout = tmo_q;
  assign m_psel      = psel_q;
  assign m_penable   = penable_q;
  assign m_pwrite    = pwrite_q;
  assign m_paddr     = paddr_q;
  assign m_pwdata    = pwdata_q;
  assign m_pstrb     = pstrb_q;

endmodule

// File: doc/apb_initiator.md
APB_INITIATOR -- requirements
Module: apb_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, max ACCESS-phase cycles waiting for pready (0 = no timeout).
REQ-002 SHALL have parameter AW, default 12, APB address width.
REQ-003 sys_clk  in  1  single clock; all state updates on rising edge.
REQ-004 sys_rst_n  in  1  asynchronous active-low reset.
REQ-005 cmd_valid  in  1  request present.
REQ-006 cmd_ready  out  1  request accepted when cmd_valid&cmd_ready at a rising edge.
REQ-007 cmd_write  in  1  1 = write, 0 = read.
REQ-008 cmd_addr  in  AW  transfer address.
REQ-009 cmd_wdata  in  32  write data.
REQ-010 cmd_strb  in  4  byte strobes for writes.
REQ-011 rsp_valid  out  1  response available.
REQ-012 rsp_ready  in  1  response consumed when rsp_valid&rsp_ready at a rising edge.
REQ-013 rsp_rdata  out  32  read data (0 for writes and timeouts).
REQ-014 rsp_err  out  1  pslverr sampled, or timeout.
REQ-015 rsp_timeout  out  1  transfer aborted by timeout.
REQ-016 m_psel, m_penable, m_pwrite  out  1 each  APB controls.
REQ-017 m_paddr  out  AW; m_pwdata  out  32; m_pstrb  out  4  APB address/data/strobe.
REQ-018 m_prdata  in  32; m_pready  in  1; m_pslverr  in  1  APB completer response.

Function
REQ-019 SHALL implement FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE, all outputs registered.
REQ-020 cmd_ready SHALL be 1 only in IDLE; accepted command fields SHALL be latched at acceptance.
REQ-021 SETUP (exactly one cycle, the cycle after acceptance): m_psel=1, m_penable=0, address/control/data driven from latched command.
REQ-022 ACCESS: m_psel=1, m_penable=1; m_paddr, m_pwrite, m_pwdata, m_pstrb SHALL stay stable until the transfer ends.
REQ-023 On rising edge with m_pready=1 in ACCESS: capture m_prdata (reads only, else 0) and m_pslverr; go to RESP; m_psel=m_penable=0 next cycle.
REQ-024 m_pstrb SHALL be driven 4'h0 for reads; m_pwdata SHALL be 0 for reads.
REQ-025 Wait-state counter SHALL clear on SETUP and increment each ACCESS cycle with m_pready=0; on reaching TIMEOUT (TIMEOUT>0): abort, deassert psel/penable, rsp_err=1, rsp_timeout=1, rsp_rdata=0, go to RESP.
REQ-026 Counter SHALL be at least clog2(TIMEOUT+1) bits and SHALL saturate, never wrap.
REQ-027 RESP: rsp_valid=1 with stable rsp_* until rsp_ready=1; then IDLE; rsp_* fields hold last values after.
REQ-028 Minimum command-to-rsp_valid latency: 3 cycles (accept edge N, SETUP N+1, ACCESS N+2 with pready=1, rsp_valid from N+3).
REQ-029 Back-to-back: new command accepted no earlier than the cycle after the response handshake; m_psel SHALL be 0 for at least one cycle between transfers.
REQ-030 m_pready/m_pslverr/m_prdata SHALL be ignored outside ACCESS.
REQ-031 m_pready=1 in the same cycle the timeout is reached SHALL complete normally (pready wins).

Reset
REQ-032 sys_rst_n=0 SHALL immediately force IDLE: m_psel=0, m_penable=0, m_pwrite=0, m_paddr=0, m_pwdata=0, m_pstrb=0, cmd_ready=0 during reset, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, counter=0.
REQ-033 Reset mid-transfer SHALL abort without a response; cmd_ready=1 from first edge after release.

Verification
REQ-034 Write addr 12'h004, data 32'h1234_5678, strb 4'hF, pready=1 at first ACCESS -> psel 1 cycle before penable, pwdata/pstrb match, rsp_valid at N+3, rsp_err=0.
REQ-035 Read addr 12'h018, completer returns 32'h0000_0001 after 3 wait states -> paddr stable 5 cycles, rsp_rdata=32'h0000_0001, pstrb=0, rsp_valid at N+6.
REQ-036 Write addr 12'h00C with pslverr=1 on completion -> rsp_err=1, rsp_timeout=0.
REQ-037 TIMEOUT=16, pready held 0 -> psel/penable drop after 16 ACCESS cycles, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-038 rsp_ready held 0 for 5 cycles then 1, cmd_valid held 1 -> rsp_* stable throughout, cmd_ready 0 until IDLE, one idle psel=0 cycle before next SETUP.
REQ-039 Assert sys_rst_n=0 mid-ACCESS -> all outputs 0 immediately, no rsp_valid, next command completes normally.
